// File: rtl/param_fetch_ctrl.sv
// Parameter fetch sequencer for the convolution parameter ROM bank.
// On a start request it walks the five weight-ROM columns of one kernel,
// tracks each issued column through the ROM read latency with a tag pipeline,
// assembles the 5x5 weight window plus bias, and presents them with a
// ready/ack handshake.
//
// state | meaning
// IDLE  | waiting for conv_start; out-of-range index pulses param_err
// ISSUE | five cycles, one weight-ROM column address per cycle
// DRAIN | waiting for the column-4 data to come back from the ROMs
// READY | w_out/bias_out held and valid until param_ack
module param_fetch_ctrl #(
  parameter int KERNEL_NUM = 6,
  parameter int ROM_LAT    = 1
) (
  input  logic         sclk,
  input  logic         s_rst_n,
  input  logic         conv_start,
  input  logic [4:0]   conv_idx,
  input  logic         param_ack,
  output logic [7:0]   param_rd_addr,
  output logic [4:0]   conv_cnt,
  input  logic [15:0]  param_w_h0,
  input  logic [15:0]  param_w_h1,
  input  logic [15:0]  param_w_h2,
  input  logic [15:0]  param_w_h3,
  input  logic [15:0]  param_w_h4,
  input  logic [15:0]  param_bias,
  output logic [399:0] w_out,
  output logic [15:0]  bias_out,
  output logic         param_ready,
  output logic         busy,
  output logic         param_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, READY} state_t;

  state_t             state;
  logic [2:0]         col;
  logic               issue_vld;
  logic [2:0]         issue_col;
  logic [ROM_LAT-1:0] tag_vld;
  logic [2:0]         tag_col [ROM_LAT];
  logic [15:0]        row_data [5];
  logic               cap_vld;
  logic [2:0]         cap_col;
  logic               start_ok;

  assign row_data[0] = param_w_h0;
  assign row_data[1] = param_w_h1;
  assign row_data[2] = param_w_h2;
  assign row_data[3] = param_w_h3;
  assign row_data[4] = param_w_h4;

  // The issue register lines up with the address register; the tag pipeline
  // then adds ROM_LAT stages so the tag emerges with the matching ROM data.
  assign cap_vld  = tag_vld[ROM_LAT-1];
  assign cap_col  = tag_col[ROM_LAT-1];
  assign start_ok = ({1'b0, conv_idx} < 6'(KERNEL_NUM));

  // Column tag pipeline: delays each issued column by the ROM read latency.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      tag_vld <= '0;
      for (int i = 0; i < ROM_LAT; i++) tag_col[i] <= 3'd0;
    end else begin
      tag_vld[0] <= issue_vld;
      tag_col[0] <= issue_col;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_col[i] <= tag_col[i-1];
      end
    end
  end

  // Sequencer FSM with registered outputs and window/bias capture.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state         <= IDLE;
      col           <= 3'd0;
      issue_vld     <= 1'b0;
      issue_col     <= 3'd0;
      param_rd_addr <= 8'd0;
      conv_cnt      <= 5'd0;
      w_out         <= '0;
      bias_out      <= 16'd0;
      param_ready   <= 1'b0;
      busy          <= 1'b0;
      param_err     <= 1'b0;
    end else begin
      param_err <= 1'b0;
      issue_vld <= 1'b0;

      if (cap_vld) begin
        for (int r = 0; r < 5; r++) begin
          for (int c = 0; c < 5; c++) begin
            if (cap_col == 3'(c)) w_out[(r*5+c)*16 +: 16] <= row_data[r];
          end
        end
        if (cap_col == 3'd4) bias_out <= param_bias;
      end

      case (state)
        IDLE: begin
          if (conv_start) begin
            if (start_ok) begin
              conv_cnt      <= conv_idx;
              param_rd_addr <= {3'b000, conv_idx} * 8'd5;
              col           <= 3'd0;
              issue_vld     <= 1'b1;
              issue_col     <= 3'd0;
              busy          <= 1'b1;
              state         <= ISSUE;
            end else begin
              param_err <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (col != 3'd4) begin
            col           <= col + 3'd1;
            param_rd_addr <= param_rd_addr + 8'd1;
            issue_vld     <= 1'b1;
            issue_col     <= col + 3'd1;
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (cap_vld && cap_col == 3'd4) begin
            param_ready <= 1'b1;
            state       <= READY;
          end
        end
        READY: begin
          if (param_ack) begin
            param_ready <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_fetch_ctrl.sv
// Bench for param_fetch_ctrl: three instances (ROM_LAT 1, 2, 3) share the
// same stimulus, each fed by its own ROM model returning {row, addr} ^ key.
module tb_param_fetch_ctrl;

  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  logic         s_rst_n;
  logic         conv_start;
  logic [4:0]   conv_idx;
  logic         param_ack;
  logic [15:0]  key;

  logic [7:0]   rd_addr  [3];
  logic [4:0]   cnt      [3];
  logic [399:0] w_out    [3];
  logic [15:0]  bias_out [3];
  logic         ready    [3];
  logic         busy     [3];
  logic         err      [3];

  logic [7:0]   a_pipe [3][3];
  logic [4:0]   c_pipe [3][3];
  logic [15:0]  wh [3][5];
  logic [15:0]  bh [3];

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [15:0] w_rom(input int r, input int a);
    return {8'(r), 8'(a)} ^ key;
  endfunction

  function automatic logic [15:0] b_rom(input int k);
    return (16'hB000 + 16'(k * 257)) ^ key;
  endfunction

  // ROM models: instance i sees data i+1 clocks after its address changes.
  always @(posedge sclk) begin
    for (int i = 0; i < 3; i++) begin
      a_pipe[i][0] <= rd_addr[i];
      c_pipe[i][0] <= cnt[i];
      for (int s = 1; s < 3; s++) begin
        a_pipe[i][s] <= a_pipe[i][s-1];
        c_pipe[i][s] <= c_pipe[i][s-1];
      end
    end
  end

  always @* begin
    for (int i = 0; i < 3; i++) begin
      for (int r = 0; r < 5; r++) wh[i][r] = {8'(r), a_pipe[i][i]} ^ key;
      bh[i] = (16'hB000 + {8'(c_pipe[i][i]), 3'b000, c_pipe[i][i]}) ^ key;
    end
  end

  param_fetch_ctrl #(.KERNEL_NUM(6), .ROM_LAT(1)) u_dut1 (
    .sclk(sclk), .s_rst_n(s_rst_n), .conv_start(conv_start), .conv_idx(conv_idx),
    .param_ack(param_ack), .param_rd_addr(rd_addr[0]), .conv_cnt(cnt[0]),
    .param_w_h0(wh[0][0]), .param_w_h1(wh[0][1]), .param_w_h2(wh[0][2]),
    .param_w_h3(wh[0][3]), .param_w_h4(wh[0][4]), .param_bias(bh[0]),
    .w_out(w_out[0]), .bias_out(bias_out[0]), .param_ready(ready[0]),
    .busy(busy[0]), .param_err(err[0]));

  param_fetch_ctrl #(.KERNEL_NUM(6), .ROM_LAT(2)) u_dut2 (
    .sclk(sclk), .s_rst_n(s_rst_n), .conv_start(conv_start), .conv_idx(conv_idx),
    .param_ack(param_ack), .param_rd_addr(rd_addr[1]), .conv_cnt(cnt[1]),
    .param_w_h0(wh[1][0]), .param_w_h1(wh[1][1]), .param_w_h2(wh[1][2]),
    .param_w_h3(wh[1][3]), .param_w_h4(wh[1][4]), .param_bias(bh[1]),
    .w_out(w_out[1]), .bias_out(bias_out[1]), .param_ready(ready[1]),
    .busy(busy[1]), .param_err(err[1]));

  param_fetch_ctrl #(.KERNEL_NUM(6), .ROM_LAT(3)) u_dut3 (
    .sclk(sclk), .s_rst_n(s_rst_n), .conv_start(conv_start), .conv_idx(conv_idx),
    .param_ack(param_ack), .param_rd_addr(rd_addr[2]), .conv_cnt(cnt[2]),
    .param_w_h0(wh[2][0]), .param_w_h1(wh[2][1]), .param_w_h2(wh[2][2]),
    .param_w_h3(wh[2][3]), .param_w_h4(wh[2][4]), .param_bias(bh[2]),
    .w_out(w_out[2]), .bias_out(bias_out[2]), .param_ready(ready[2]),
    .busy(busy[2]), .param_err(err[2]));

  task automatic chk(input string tag, input logic [399:0] obs, input logic [399:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s addr%0d", tag, i), 400'(rd_addr[i]), 400'd0);
      chk($sformatf("%s cnt%0d", tag, i), 400'(cnt[i]), 400'd0);
      chk($sformatf("%s w%0d", tag, i), w_out[i], 400'd0);
      chk($sformatf("%s bias%0d", tag, i), 400'(bias_out[i]), 400'd0);
      chk($sformatf("%s ready%0d", tag, i), 400'(ready[i]), 400'd0);
      chk($sformatf("%s busy%0d", tag, i), 400'(busy[i]), 400'd0);
      chk($sformatf("%s err%0d", tag, i), 400'(err[i]), 400'd0);
    end
  endtask

  // Called at a negedge; returns at a negedge with all instances idle.
  task automatic run_fetch(input int k, input int hold, input bit inject);
    logic [399:0] exp_w;
    logic [15:0]  exp_b;
    int           rdy [3];
    bit           all_rdy;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        exp_w[(r*5+c)*16 +: 16] = w_rom(r, k*5 + c);
    exp_b = b_rom(k);
    for (int i = 0; i < 3; i++) rdy[i] = -1;

    conv_idx   = 5'(k);
    conv_start = 1'b1;
    for (int n = 0; n <= 20; n++) begin
      @(negedge sclk);
      conv_start = 1'b0;
      conv_idx   = 5'($urandom);
      param_ack  = inject && (n <= 3) && ($urandom_range(0, 1) == 1);
      for (int i = 0; i < 3; i++) begin
        if (n <= 4) chk($sformatf("addr%0d n%0d", i, n), 400'(rd_addr[i]), 400'(k*5 + n));
        chk($sformatf("cnt%0d", i), 400'(cnt[i]), 400'(k));
        chk($sformatf("busy%0d", i), 400'(busy[i]), 400'd1);
        chk($sformatf("err%0d", i), 400'(err[i]), 400'd0);
        if (ready[i] && rdy[i] < 0) rdy[i] = n;
      end
      if (inject && (n == 1 || n == 5 || n == 6 || n == 7)) conv_start = 1'b1;
      all_rdy = (rdy[0] >= 0) && (rdy[1] >= 0) && (rdy[2] >= 0);
      if (all_rdy) break;
    end
    conv_start = 1'b0;
    param_ack  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ready_edge lat%0d", i+1), 400'(rdy[i]), 400'(6 + i));
      chk($sformatf("w lat%0d", i+1), w_out[i], exp_w);
      chk($sformatf("bias lat%0d", i+1), 400'(bias_out[i]), 400'(exp_b));
    end

    for (int h = 0; h < hold; h++) begin
      @(negedge sclk);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("hold w%0d", i), w_out[i], exp_w);
        chk($sformatf("hold bias%0d", i), 400'(bias_out[i]), 400'(exp_b));
        chk($sformatf("hold ready%0d", i), 400'(ready[i]), 400'd1);
        chk($sformatf("hold addr%0d", i), 400'(rd_addr[i]), 400'(k*5 + 4));
        chk($sformatf("hold err%0d", i), 400'(err[i]), 400'd0);
      end
      conv_start = inject && ($urandom_range(0, 1) == 1);
      conv_idx   = 5'($urandom);
    end

    param_ack  = 1'b1;
    conv_start = inject;
    @(negedge sclk);
    param_ack  = 1'b0;
    conv_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ack ready%0d", i), 400'(ready[i]), 400'd0);
      chk($sformatf("ack busy%0d", i), 400'(busy[i]), 400'd0);
      chk($sformatf("ack err%0d", i), 400'(err[i]), 400'd0);
      chk($sformatf("ack w%0d", i), w_out[i], exp_w);
      chk($sformatf("ack addr%0d", i), 400'(rd_addr[i]), 400'(k*5 + 4));
    end
    @(negedge sclk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("post busy%0d", i), 400'(busy[i]), 400'd0);
      chk($sformatf("post cnt%0d", i), 400'(cnt[i]), 400'(k));
    end
  endtask

  task automatic run_reject(input int k);
    logic [7:0] pa [3];
    logic [4:0] pc [3];
    for (int i = 0; i < 3; i++) begin
      pa[i] = rd_addr[i];
      pc[i] = cnt[i];
    end
    conv_idx   = 5'(k);
    conv_start = 1'b1;
    @(negedge sclk);
    conv_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rej err%0d", i), 400'(err[i]), 400'd1);
      chk($sformatf("rej busy%0d", i), 400'(busy[i]), 400'd0);
      chk($sformatf("rej ready%0d", i), 400'(ready[i]), 400'd0);
      chk($sformatf("rej addr%0d", i), 400'(rd_addr[i]), 400'(pa[i]));
      chk($sformatf("rej cnt%0d", i), 400'(cnt[i]), 400'(pc[i]));
    end
    @(negedge sclk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rej pulse%0d", i), 400'(err[i]), 400'd0);
      chk($sformatf("rej busy2_%0d", i), 400'(busy[i]), 400'd0);
    end
  endtask

  initial begin
    s_rst_n    = 1'b1;
    conv_start = 1'b0;
    conv_idx   = 5'd0;
    param_ack  = 1'b0;
    key        = 16'h0000;
    #2 s_rst_n = 1'b0;
    @(negedge sclk);
    @(negedge sclk);
    check_zero("reset");
    s_rst_n = 1'b1;
    @(negedge sclk);

    run_fetch(2, 20, 1'b0);
    run_fetch(5, 3, 1'b0);
    run_reject(6);
    run_fetch(4, 4, 1'b1);

    // Abort a fetch at column 3 with an asynchronous reset.
    conv_idx   = 5'd3;
    conv_start = 1'b1;
    @(negedge sclk);
    conv_start = 1'b0;
    repeat (3) @(negedge sclk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("abort addr%0d", i), 400'(rd_addr[i]), 400'd18);
    s_rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge sclk);
    s_rst_n = 1'b1;
    check_zero("after_rst");
    run_fetch(1, 2, 1'b0);

    for (int t = 0; t < 25; t++) begin
      int k;
      key = 16'($urandom);
      k   = $urandom_range(0, 9);
      if (k >= 6) run_reject(k);
      else        run_fetch(k, $urandom_range(0, 5), $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
